// File: rtl/mmu_pkg.sv
// Constants and lane type shared between the MMU array and its result collector.
package mmu_pkg;

  localparam int ARRAY_DIM = 16;
  localparam int ACC_WIDTH = 20;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/mmu_skew_line.sv
// Fixed-depth register delay line for one lane plus its valid bit; STAGES=0 is a wire.
module mmu_skew_line #(
  parameter int DATA_W = 20,
  parameter int STAGES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_vld,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_vld,
  output logic signed [DATA_W-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset_n ^ clear;
      assign out_vld     = in_vld;
      assign out_data    = in_data;
    end else begin : g_delay
      logic [STAGES-1:0]        vld_p;
      logic signed [DATA_W-1:0] data_p [STAGES];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_p <= '0;
        end else if (clear) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= in_vld;
          for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_p[0] <= in_data;
        for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
      end

      assign out_vld  = vld_p[STAGES-1];
      assign out_data = data_p[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mmu_result_collector.sv
// De-skews the MMU aout wavefront into whole rows and streams them out through a small FIFO.
// Optional MMU_COLLECT_ROW_IDX_EN adds a per-row index output (out_row_idx).
module mmu_result_collector #(
  parameter int ARRAY_DIM  = mmu_pkg::ARRAY_DIM,
  parameter int ACC_WIDTH  = mmu_pkg::ACC_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0]    aout,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0]    out_data,
`ifdef MMU_COLLECT_ROW_IDX_EN
  output logic [$clog2(ARRAY_DIM)-1:0]      out_row_idx,
`endif
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow
);
  import mmu_pkg::*;

  localparam int ROW_W = ARRAY_DIM*ACC_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ROW_W-1:0]     row_al;
  logic                 row_vld_al;
  logic                 unused_vld_data;
  logic [ARRAY_DIM-1:0] unused_lane_vld;

  // Skew stage: lane k waits ARRAY_DIM-1-k cycles so the whole row lines up
  mmu_skew_line #(.DATA_W(1), .STAGES(ARRAY_DIM-1)) u_vld_line (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_vld   (in_valid),
    .in_data  (1'b0),
    .out_vld  (row_vld_al),
    .out_data (unused_vld_data)
  );

  for (genvar k = 0; k < ARRAY_DIM; k++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] lane_out;
    mmu_skew_line #(.DATA_W(ACC_WIDTH), .STAGES(ARRAY_DIM-1-k)) u_line (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_vld   (1'b1),
      .in_data  (aout[k*ACC_WIDTH +: ACC_WIDTH]),
      .out_vld  (unused_lane_vld[k]),
      .out_data (lane_out)
    );
    assign row_al[k*ACC_WIDTH +: ACC_WIDTH] = lane_out;
  end

  // FIFO stage: aligned row pushed at end of its alignment cycle, head held in out_data
  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] count, cnt_nxt;
  logic             full, push, pop, new_head_is_push;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !clear;
  assign push      = row_vld_al && !clear && (!full || pop);

  always_comb begin
    rd_nxt           = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    cnt_nxt          = count + CNT_W'(push) - CNT_W'(pop);
    // the next head comes from the incoming row when no older entry survives this cycle
    new_head_is_push = (count == '0) || ((count == CNT_W'(1)) && pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= row_al;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      out_data <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      if (row_vld_al && full && !pop) overflow <= 1'b1;
      if (cnt_nxt != '0) out_data <= new_head_is_push ? row_al : mem[rd_nxt];
    end
  end

  assign fifo_count = count;

`ifdef MMU_COLLECT_ROW_IDX_EN
  localparam int IDX_W = $clog2(ARRAY_DIM);

  logic [IDX_W-1:0] idx_mem [FIFO_DEPTH];
  logic [IDX_W-1:0] row_idx;

  always_ff @(posedge clk) begin
    if (push) idx_mem[wr_ptr] <= row_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_idx     <= '0;
      out_row_idx <= '0;
    end else if (clear) begin
      row_idx     <= '0;
    end else begin
      if (push) row_idx <= row_idx + IDX_W'(1);
      if (cnt_nxt != '0) out_row_idx <= new_head_is_push ? row_idx : idx_mem[rd_nxt];
    end
  end
`endif

endmodule

// File: tb/tb_mmu_result_collector.sv
// Directed bench for mmu_result_collector: skewed wavefront driver plus assertion checks.
module tb_mmu_result_collector;
  import mmu_pkg::*;

  localparam int ROW_W = ARRAY_DIM*ACC_WIDTH;
  localparam int CNT_W = $clog2(4) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic             in_valid;
  logic [ROW_W-1:0] aout;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_data;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
`ifdef MMU_COLLECT_ROW_IDX_EN
  logic [$clog2(ARRAY_DIM)-1:0] out_row_idx;
`endif

  mmu_result_collector #(.ARRAY_DIM(ARRAY_DIM), .ACC_WIDTH(ACC_WIDTH), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .aout       (aout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef MMU_COLLECT_ROW_IDX_EN
    .out_row_idx(out_row_idx),
`endif
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;
  int rs[$];
  int rb[$];
  logic seen;

  function automatic logic [ROW_W-1:0] row_vec(input int base);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int k = 0; k < ARRAY_DIM; k++) v[k*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(base + k);
    return v;
  endfunction

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_row(input int start, input int base);
    rs.push_back(start);
    rb.push_back(base);
  endtask

  // Present the wavefront for cycle cyc, then step one clock
  task automatic tick();
    logic [ROW_W-1:0] a;
    logic             v;
    a = '0;
    v = 1'b0;
    for (int i = 0; i < rs.size(); i++) begin
      int d;
      d = cyc - rs[i];
      if (d == 0) v = 1'b1;
      if (d >= 0 && d < ARRAY_DIM) a[d*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(rb[i] + d);
    end
    aout     = a;
    in_valid = v;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    aout      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset_out_valid", ROW_W'(out_valid), ROW_W'(0));
    check("reset_out_data", out_data, '0);
    check("reset_count", ROW_W'(fifo_count), ROW_W'(0));
    check("reset_overflow", ROW_W'(overflow), ROW_W'(0));
    reset_n = 1'b1;

    // single row
    out_ready = 1'b1;
    add_row(cyc, 100);
    repeat (15) tick();
    check("single_not_yet", ROW_W'(out_valid), ROW_W'(0));
    tick();
    check("single_valid", ROW_W'(out_valid), ROW_W'(1));
    check("single_data", out_data, row_vec(100));
    check("single_count1", ROW_W'(fifo_count), ROW_W'(1));
    tick();
    check("single_drained", ROW_W'(out_valid), ROW_W'(0));
    check("single_count0", ROW_W'(fifo_count), ROW_W'(0));

    // back-to-back rows
    for (int r = 0; r < 4; r++) add_row(cyc + r, 16*r);
    repeat (16) tick();
    for (int r = 0; r < 4; r++) begin
      check($sformatf("b2b_valid%0d", r), ROW_W'(out_valid), ROW_W'(1));
      check($sformatf("b2b_data%0d", r), out_data, row_vec(16*r));
      check($sformatf("b2b_count%0d", r), ROW_W'(fifo_count), ROW_W'(1));
      tick();
    end
    check("b2b_empty", ROW_W'(out_valid), ROW_W'(0));

    // backpressure and overflow
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) add_row(cyc + r, 1000 + 16*r);
    repeat (19) tick();
    check("bp_count_full", ROW_W'(fifo_count), ROW_W'(4));
    check("bp_no_ovf_yet", ROW_W'(overflow), ROW_W'(0));
    check("bp_head_row0", out_data, row_vec(1000));
    tick();
    check("bp_count_held", ROW_W'(fifo_count), ROW_W'(4));
    check("bp_overflow", ROW_W'(overflow), ROW_W'(1));
    check("bp_head_stable", out_data, row_vec(1000));
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      check($sformatf("bp_valid%0d", r), ROW_W'(out_valid), ROW_W'(1));
      check($sformatf("bp_data%0d", r), out_data, row_vec(1000 + 16*r));
      tick();
    end
    check("bp_empty", ROW_W'(out_valid), ROW_W'(0));
    check("bp_ovf_sticky", ROW_W'(overflow), ROW_W'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("bp_ovf_cleared", ROW_W'(overflow), ROW_W'(0));

    // full with simultaneous push and pop
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) add_row(cyc + r, 2000 + 16*r);
    repeat (19) tick();
    check("fpp_count_full", ROW_W'(fifo_count), ROW_W'(4));
    check("fpp_head_row0", out_data, row_vec(2000));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fpp_count_same", ROW_W'(fifo_count), ROW_W'(4));
    check("fpp_no_overflow", ROW_W'(overflow), ROW_W'(0));
    check("fpp_head_row1", out_data, row_vec(2016));
    out_ready = 1'b1;
    for (int r = 1; r < 5; r++) begin
      check($sformatf("fpp_data%0d", r), out_data, row_vec(2000 + 16*r));
      tick();
    end
    check("fpp_empty", ROW_W'(fifo_count), ROW_W'(0));

    // clear with rows in flight, one aligning on the clear cycle, one entering on it
    out_ready = 1'b0;
    add_row(cyc, 3000);
    add_row(cyc + 1, 3100);
    add_row(cyc + 10, 3200);
    add_row(cyc + 16, 3300);
    repeat (16) tick();
    check("clr_pre_count", ROW_W'(fifo_count), ROW_W'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid", ROW_W'(out_valid), ROW_W'(0));
    check("clr_count", ROW_W'(fifo_count), ROW_W'(0));
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("clr_no_rows_emerge", ROW_W'(seen), ROW_W'(0));

    // asynchronous reset mid-operation, signed lane data
    out_ready = 1'b0;
    add_row(cyc, -50);
    add_row(cyc + 5, 4000);
    repeat (16) tick();
    check("rst_pre_valid", ROW_W'(out_valid), ROW_W'(1));
    check("rst_pre_data_signed", out_data, row_vec(-50));
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", ROW_W'(out_valid), ROW_W'(0));
    check("rst_async_data", out_data, '0);
    check("rst_async_count", ROW_W'(fifo_count), ROW_W'(0));
    tick();
    #3;
    reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_rows_emerge", ROW_W'(seen), ROW_W'(0));

`ifdef MMU_COLLECT_ROW_IDX_EN
    for (int r = 0; r < 18; r++) add_row(cyc + r, 5000 + 16*r);
    repeat (16) tick();
    for (int r = 0; r < 18; r++) begin
      check($sformatf("idx_valid%0d", r), ROW_W'(out_valid), ROW_W'(1));
      check($sformatf("idx_value%0d", r), ROW_W'(out_row_idx), ROW_W'(r % ARRAY_DIM));
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
